// File: rtl/ray_tracer_pkg.sv
// ----------------------------------------------------------------------------
// ray_tracer_pkg
// Shared widths, the triangle descriptor record and a small signed multiply
// helper for the multi-triangle ray/triangle intersection block.
// No ports (package).
// ----------------------------------------------------------------------------
package ray_tracer_pkg;

    localparam int COL_W = 10;        // pixel column width
    localparam int ROW_W = 9;         // pixel row width
    localparam int Z_W   = 3;         // vertex Z / output depth width
    localparam int QM    = 23;        // integer bits of det / inv_det
    localparam int QF    = 23;        // fraction bits of inv_det
    localparam int S_W   = COL_W + 1; // width of the ray-origin offset vector

    typedef struct packed {
        logic signed [COL_W:0]   e1x;
        logic signed [ROW_W:0]   e1y;
        logic signed [Z_W:0]     e1z;
        logic signed [COL_W:0]   e2x;
        logic signed [ROW_W:0]   e2y;
        logic signed [Z_W:0]     e2z;
        logic [COL_W-1:0]        v0x;
        logic [ROW_W-1:0]        v0y;
        logic [Z_W-1:0]          v0z;
        logic [QM-1:0]           det;
        logic [QM+QF-1:0]        inv_det;
        logic                    en;
    } tri_desc_t;

    // Signed product of two offset/edge terms, kept at QM bits.
    function automatic logic signed [QM-1:0] smul(input logic signed [S_W-1:0] a,
                                                 input logic signed [S_W-1:0] b);
        return QM'(a) * QM'(b);
    endfunction

endpackage

// File: rtl/ray_tri_isect_pipe.sv
// ----------------------------------------------------------------------------
// ray_tri_isect_pipe
// Three-stage ray/triangle intersection pipeline. One descriptor per cycle.
//   clk, rst          clock, synchronous active-high reset (clears valids)
//   in_valid, in_idx  issue strobe and slot index; the slot's en gates valid
//   col, row          pixel under test
//   desc              triangle descriptor
//   out_valid/out_idx/out_hit/out_z  stage-3 result
// ----------------------------------------------------------------------------
module ray_tri_isect_pipe
    import ray_tracer_pkg::*;
#(
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [COL_W-1:0] col,
    input  logic [ROW_W-1:0] row,
    input  tri_desc_t        desc,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_hit,
    output logic [Z_W-1:0]   out_z
);

    localparam int PW = QM + QF + QM + 2;  // inv_det * ut full product width
    localparam logic signed [PW-1:0] HALF = PW'(1) << (QF - 1);
    localparam logic signed [PW-1:0] ZMAX = PW'(2 ** Z_W - 1);

    // ---------------- stage 1: offset vector, u and q = s x e1 -------------
    logic signed [S_W-1:0] sx, sy, sz;
    logic signed [QM-1:0]  u1, qx1, qy1, qz1;

    always_comb begin
        // NOTE: combinational blocks use blocking '=', sequential ones '<='.
        sx  = $signed(S_W'(col)) - $signed(S_W'(desc.v0x));
        sy  = $signed(S_W'(row)) - $signed(S_W'(desc.v0y));
        sz  = -$signed(S_W'(desc.v0z));
        u1  = smul(sx, S_W'(desc.e2y)) - smul(sy, S_W'(desc.e2x));
        qx1 = smul(sy, S_W'(desc.e1z)) - smul(sz, S_W'(desc.e1y));
        qy1 = smul(sz, S_W'(desc.e1x)) - smul(sx, S_W'(desc.e1z));
        qz1 = smul(sx, S_W'(desc.e1y)) - smul(sy, S_W'(desc.e1x));
    end

    logic                    s1_valid;
    logic [IDX_W-1:0]        s1_idx;
    logic signed [QM-1:0]    s1_u, s1_qx, s1_qy, s1_qz;
    logic signed [S_W-1:0]   s1_e2x, s1_e2y, s1_e2z;
    logic [QM-1:0]           s1_det;
    logic [QM+QF-1:0]        s1_inv;

    // ---------------- stage 2: v, ut and the inside test --------------------
    logic signed [QM-1:0]  v2;
    logic signed [QM:0]    ut2, u_e, v_e, det_e, uv_sum;
    logic                  hit2;

    always_comb begin
        v2     = -s1_qz;
        ut2    = (QM+1)'(s1_e2x) * (QM+1)'(s1_qx)
               + (QM+1)'(s1_e2y) * (QM+1)'(s1_qy)
               + (QM+1)'(s1_e2z) * (QM+1)'(s1_qz);
        u_e    = (QM+1)'(s1_u);
        v_e    = (QM+1)'(v2);
        det_e  = $signed({1'b0, s1_det});
        uv_sum = u_e + v_e;  // one guard bit so the sum cannot wrap
        hit2   = !(s1_u[QM-1] || v2[QM-1] || (u_e > det_e) || (v_e > det_e) ||
                   (uv_sum > det_e));
    end

    logic                  s2_valid;
    logic [IDX_W-1:0]      s2_idx;
    logic                  s2_hit;
    logic signed [QM:0]    s2_ut;
    logic [QM+QF-1:0]      s2_inv;

    // ---------------- stage 3: depth = -round(inv_det * ut), saturated ----
    logic signed [PW-1:0]  prod3, rnd3, d3;
    logic [Z_W-1:0]        z3;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise a latch is inferred.
        z3    = '0;
        prod3 = PW'($signed({1'b0, s2_inv})) * PW'(s2_ut);
        rnd3  = (prod3 + HALF) >>> QF;  // round half toward +inf
        d3    = -rnd3;
        if (d3[PW-1])
            z3 = '0;
        else if (d3 > ZMAX)
            z3 = Z_W'(2 ** Z_W - 1);
        else
            z3 = d3[Z_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            s1_valid  <= in_valid && desc.en;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    // Datapath registers carry no reset; only the valids qualify them.
    always_ff @(posedge clk) begin
        s1_idx  <= in_idx;
        s1_u    <= u1;
        s1_qx   <= qx1;
        s1_qy   <= qy1;
        s1_qz   <= qz1;
        s1_e2x  <= S_W'(desc.e2x);
        s1_e2y  <= S_W'(desc.e2y);
        s1_e2z  <= S_W'(desc.e2z);
        s1_det  <= desc.det;
        s1_inv  <= desc.inv_det;

        s2_idx  <= s1_idx;
        s2_hit  <= hit2;
        s2_ut   <= ut2;
        s2_inv  <= s1_inv;

        out_idx <= s2_idx;
        out_hit <= s2_hit;
        out_z   <= z3;
    end

endmodule

// File: rtl/ray_tracer_multi_tri.sv
// ----------------------------------------------------------------------------
// ray_tracer_multi_tri
// Nearest-hit resolve over a bank of NUM_TRI triangles for one pixel at a time.
//   clk, rst                     clock, synchronous active-high reset
//   tri_we/tri_addr/tri_en/...   descriptor write port (accepted in IDLE only)
//   pixel_valid/ready/col/row    pixel request handshake
//   result_valid/ready           result handshake
//   result_hit/idx/z             nearest enabled triangle covering the pixel
//   busy                         scan in progress or result pending
// ----------------------------------------------------------------------------
module ray_tracer_multi_tri
    import ray_tracer_pkg::*;
#(
    parameter  int NUM_TRI = 4,
    localparam int IDX_W   = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tri_we,
    input  logic [IDX_W-1:0]        tri_addr,
    input  logic                    tri_en,
    input  logic signed [COL_W:0]   tri_e1x,
    input  logic signed [ROW_W:0]   tri_e1y,
    input  logic signed [Z_W:0]     tri_e1z,
    input  logic signed [COL_W:0]   tri_e2x,
    input  logic signed [ROW_W:0]   tri_e2y,
    input  logic signed [Z_W:0]     tri_e2z,
    input  logic [COL_W-1:0]        tri_v0x,
    input  logic [ROW_W-1:0]        tri_v0y,
    input  logic [Z_W-1:0]          tri_v0z,
    input  logic [QM-1:0]           tri_det,
    input  logic [QM+QF-1:0]        tri_inv_det,
    input  logic                    pixel_valid,
    output logic                    pixel_ready,
    input  logic [COL_W-1:0]        pixel_col,
    input  logic [ROW_W-1:0]        pixel_row,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    result_hit,
    output logic [IDX_W-1:0]        result_idx,
    output logic [Z_W-1:0]          result_z,
    output logic                    busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] issue_cnt;
    logic [1:0]       drain_cnt;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             best_hit;
    logic [IDX_W-1:0] best_idx;
    logic [Z_W-1:0]   best_z;

    // ---------------- descriptor bank ---------------------------------------
    tri_desc_t bank [NUM_TRI];
    tri_desc_t wr_desc;

    always_comb begin
        wr_desc = '{e1x: tri_e1x, e1y: tri_e1y, e1z: tri_e1z,
                    e2x: tri_e2x, e2y: tri_e2y, e2z: tri_e2z,
                    v0x: tri_v0x, v0y: tri_v0y, v0z: tri_v0z,
                    det: tri_det, inv_det: tri_inv_det, en: tri_en};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the enable bits are reset; geometry is don't-care
            // while its slot is disabled, so the storage stays reset-free.
            for (int i = 0; i < NUM_TRI; i++) bank[i].en <= 1'b0;
        end else if (tri_we && state == ST_IDLE &&
                     ({1'b0, tri_addr} < (IDX_W+1)'(NUM_TRI))) begin
            bank[tri_addr] <= wr_desc;
        end
    end

    // ---------------- intersection pipeline --------------------------------
    logic             p_valid, p_hit;
    logic [IDX_W-1:0] p_idx;
    logic [Z_W-1:0]   p_z;

    ray_tri_isect_pipe #(.IDX_W(IDX_W)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (state == ST_SCAN),
        .in_idx    (issue_cnt),
        .col       (col_q),
        .row       (row_q),
        .desc      (bank[issue_cnt]),
        .out_valid (p_valid),
        .out_idx   (p_idx),
        .out_hit   (p_hit),
        .out_z     (p_z)
    );

    // ---------------- FSM and depth resolve --------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            issue_cnt    <= '0;
            drain_cnt    <= '0;
            pixel_ready  <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            best_hit     <= 1'b0;
            best_idx     <= '0;
            best_z       <= '0;
        end else begin
            // Strictly-less keeps the earlier (lower) index on equal depth.
            if (p_valid && p_hit && (!best_hit || p_z < best_z)) begin
                best_hit <= 1'b1;
                best_idx <= p_idx;
                best_z   <= p_z;
            end
            unique case (state)
                ST_IDLE: if (pixel_valid) begin
                    col_q       <= pixel_col;
                    row_q       <= pixel_row;
                    best_hit    <= 1'b0;
                    best_idx    <= '0;
                    best_z      <= '0;
                    issue_cnt   <= '0;
                    pixel_ready <= 1'b0;
                    busy        <= 1'b1;
                    state       <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (issue_cnt == IDX_W'(NUM_TRI - 1)) begin
                        drain_cnt <= '0;
                        state     <= ST_DRAIN;
                    end else begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Last issued slot leaves stage 3 on the third edge.
                    if (drain_cnt == 2'd2) begin
                        result_valid <= 1'b1;
                        state        <= ST_DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_DONE: if (result_ready) begin
                    result_valid <= 1'b0;
                    busy         <= 1'b0;
                    pixel_ready  <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign result_hit = best_hit;
    assign result_idx = best_idx;
    assign result_z   = best_z;

endmodule
